serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder.sv | 19 +
 rtl/serial_adder.sv | 161 ++++++++++++++++
 tb/tb_serial_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     state_t   - controller state encoding (IDLE, RUN, DONE)
//     cnt_width - width of the bit counter for a given operand width,
//                 never less than one bit so WIDTH=1 still has a counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     a, b  in  operand bits
//     cin   in  carry in
//     sum   out a ^ b ^ cin
//     cout  out majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. One full_adder cell processes one operand
//   bit pair per clock, LSB first; the carry is registered between cycles.
//   Result (sum + carry-out) appears WIDTH clocks after the operands are
//   accepted and is held until the consumer takes it.
//
//   Build option: define SERIAL_ADDER_SUB_EN to add the in_sub port. With
//   in_sub=1 the block computes in_a - in_b (mod 2^WIDTH); out_cout=1 then
//   means "no borrow". Without the macro the block only adds.
//
//   Handshakes: a transfer happens on a rising clk edge where both valid and
//   ready are high. in_ready is high only in IDLE; out_valid is high only in
//   DONE, and out_sum/out_cout are stable for the whole time it is high.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset (aborts any operation)
//     in_valid   in   operand set valid
//     in_ready   out  block can accept operands
//     in_a/in_b  in   WIDTH-bit operands
//     in_cin     in   carry-in to bit 0
//     in_sub     in   subtract select (only with SERIAL_ADDER_SUB_EN)
//     out_valid  out  result valid
//     out_ready  in   consumer accepts result
//     out_sum    out  WIDTH-bit sum
//     out_cout   out  carry out of bit WIDTH-1
//     busy       out  high in RUN or DONE
//     dbg_state  out  current controller state (state_t encoding)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    // Operand B and initial carry as loaded into the datapath. Subtraction
    // is a + ~b + 1, so the caller's carry-in is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load   = in_sub ? ~in_b : in_b;
    assign cin_load = in_sub ? 1'b1  : in_cin;
`else
    assign b_load   = in_b;
    assign cin_load = in_cin;
`endif

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // Written as a shift/or so WIDTH=1 needs no special slice.
    assign sum_next = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)                 state_next = RUN;
            RUN:     if (last_bit)               state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // in_ready is gated by rst_n so it reads 0 for the whole reset pulse.
    always_comb begin
        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
        dbg_state = state;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr  <= in_a;
                        b_sr  <= b_load;
                        carry <= cin_load;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        out_sum  <= sum_next;
                        out_cout <= fa_cout;
                    end
                end
                default: begin
                    // DONE: result registers hold until the next operation.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // main instance (WIDTH=8)
    logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [W-1:0] in_a, in_b, out_sum;
    logic [1:0]   dbg_state;
    logic         in_sub;

    // WIDTH=1 instance
    logic         n1_in_valid, n1_in_ready, n1_in_cin, n1_out_valid, n1_out_ready;
    logic         n1_out_cout, n1_busy;
    logic [0:0]   n1_in_a, n1_in_b, n1_out_sum;
    logic [1:0]   n1_dbg_state;

    int errors = 0;
    int checks = 0;

    logic [W:0] exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n1_in_valid),
        .in_ready  (n1_in_ready),
        .in_a      (n1_in_a),
        .in_b      (n1_in_b),
        .in_cin    (n1_in_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .in_sub    (1'b0),
`endif
        .out_valid (n1_out_valid),
        .out_ready (n1_out_ready),
        .out_sum   (n1_out_sum),
        .out_cout  (n1_out_cout),
        .busy      (n1_busy),
        .dbg_state (n1_dbg_state)
    );

    // ---------------- reference model ----------------
    // Plain arithmetic: {cout, sum} of a+b+cin, or {a>=b, a-b} for subtract.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: out_valid=1 with empty expected queue at %0t", $time);
            end else begin
                if ({out_cout, out_sum} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL sb_result: got 0x%0h, expected 0x%0h at %0t",
                             {out_cout, out_sum}, exp_q[0], $time);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W:0] lit, input int hold);
        int         lat;
        int         wait_cnt;
        logic [W:0] res;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        check("model_pin", {55'd0, model(a, b, cin, sub)}, {55'd0, lit});
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_run", {63'd0, busy}, 64'd1);
        check("in_ready_run", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, W);
        res = {out_cout, out_sum};
        check("literal", {55'd0, res}, {55'd0, lit});
        // backpressure: result must hold and new operands must be ignored
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            @(posedge clk); #1;
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold", {55'd0, out_cout, out_sum}, {55'd0, res});
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", {63'd0, out_valid}, 64'd0);
        check("post_in_ready", {63'd0, in_ready}, 64'd1);
        check("post_busy", {63'd0, busy}, 64'd0);
        check("post_keep", {55'd0, out_cout, out_sum}, {55'd0, res});
    endtask

    task automatic run_w1(input logic a, input logic b, input logic cin);
        int         lat;
        logic [1:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        n1_in_a = a; n1_in_b = b; n1_in_cin = cin; n1_in_valid = 1'b1;
        check("w1_in_ready", {63'd0, n1_in_ready}, 64'd1);
        @(posedge clk); #1;
        n1_in_valid = 1'b0;
        lat = 0;
        while (!n1_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w1_latency", lat, 1);
        check("w1_result", {62'd0, n1_out_cout, n1_out_sum}, {62'd0, exp});
        n1_out_ready = 1'b1;
        @(posedge clk); #1;
        n1_out_ready = 1'b0;
        check("w1_done", {63'd0, n1_out_valid}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        n1_in_valid = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_in_cin = 1'b0; n1_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_sum", {55'd0, out_cout, out_sum}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);

        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 9'h101, 5);
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0);

        // reset in the middle of an operation
        in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back(model(8'hAA, 8'h55, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd0);
        check("abort_sum", {55'd0, out_cout, out_sum}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_rel_ready", {63'd0, in_ready}, 64'd1);
        check("abort_no_result", {63'd0, out_valid}, 64'd0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 9'h002, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 0);
        run_op(8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF, 0);
        run_op(8'h10, 8'h01, 1'b1, 1'b1, 9'h10F, 2);
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 9'h08D, 0);
`endif

        // WIDTH=1 instance: all eight input combinations
        for (int k = 0; k < 8; k++) begin
            run_w1(k[2], k[1], k[0]);
        end

        repeat (2) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
